// File: rtl/program_loader.sv
// Purpose : framed byte-stream bootloader; writes payload bytes into program memory and
//           holds the CPU in reset until a frame's checksum verifies.
// Latency : every output is registered, one cycle after the rx_valid edge that causes it.
// Backpressure: none; accepts one byte per cycle back-to-back, one write per payload byte.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   rx_data, rx_valid      byte stream from the UART receiver (one-cycle strobe per byte)
//   mem_we/addr/wdata      program memory write port, one cycle per payload byte
//   cpu_hold               1 holds the CPU in reset
//   busy                   1 while a frame is being decoded
//   load_done              one-cycle pulse on a good frame
//   load_error             sticky; cleared by the next accepted sync byte or reset
module program_loader #(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          DATA_WIDTH     = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic [7:0]  sum_add;
    logic [15:0] len_full;

    assign sum_add  = sum_q + rx_data;
    assign len_full = {len_q[15:8], rx_data};

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        len_d        = len_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = 1'b0;
        load_error_d = load_error_q;

        if (state_q == S_IDLE) begin
            tmo_d = '0;
            if (rx_valid && rx_data == SYNC_BYTE) begin
                state_d      = S_ADDR_HI;
                cpu_hold_d   = 1'b1;
                load_error_d = 1'b0;
                sum_d        = 8'h00;
            end
        end else if (rx_valid) begin
            // Every byte after SYNC, including CHK, is part of the checksum.
            tmo_d = '0;
            sum_d = sum_add;
            case (state_q)
                S_ADDR_HI: begin
                    hi_d    = rx_data;
                    state_d = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d  = ADDR_WIDTH'({hi_q, rx_data});
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d   = len_full;
                    state_d = (len_full == 16'h0000) ? S_CHECK : S_DATA;
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_WIDTH'(rx_data);
                    addr_d      = addr_q + 1'b1;
                    len_d       = len_q - 16'd1;
                    if (len_q == 16'd1) state_d = S_CHECK;
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (sum_add == 8'h00) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Idle for TIMEOUT_CYCLES cycles since the last byte: abandon the frame.
            // cpu_hold is left set so a half-loaded image never runs.
            state_d      = S_IDLE;
            load_error_d = 1'b1;
            tmo_d        = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad frames, address wrap, zero length,
// idle noise, inter-byte timeout and asynchronous reset mid-payload.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold, busy, load_done, load_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log filled by the monitor: {addr, data}.
    logic [23:0] wr_q[$];
    int          done_cnt;

    program_loader #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // Sample 1ns after each rising edge so the log never races the edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
        if (load_done === 1'b1) done_cnt++;
    end

    // Called at a falling edge: present one byte for one cycle, return at the next
    // falling edge with the registered reaction to that byte visible.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 25'h0) begin n_fail++; $display("FAIL reset_mem got %h want 0", {mem_we, mem_addr, mem_wdata}); end
        n_checks++; if ({cpu_hold, busy, load_done, load_error} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cpu_hold, busy, load_done, load_error}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_log();
        drive(8'hA5);
        n_checks++; if ({cpu_hold, busy} !== 2'b11) begin n_fail++; $display("FAIL good_sync_hold got %b want 11", {cpu_hold, busy}); end
        drive(8'hF0); drive(8'h00); drive(8'h00); drive(8'h03);
        drive(8'h3E); drive(8'hFF); drive(8'h01);
        n_checks++; if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL good_early_done got done=%b hold=%b want 0 1", load_done, cpu_hold); end
        drive(8'hCF);
        n_checks++; if ({load_done, cpu_hold, load_error, busy} !== 4'b1000) begin n_fail++; $display("FAIL good_done got %b want 1000", {load_done, cpu_hold, load_error, busy}); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_q.size() !== 3) begin n_fail++; $display("FAIL good_wr_count got %0d want 3", wr_q.size()); end
        else begin
            n_checks++; if (wr_q[0] !== 24'hF0003E || wr_q[1] !== 24'hF001FF || wr_q[2] !== 24'hF00201) begin n_fail++; $display("FAIL good_wr_data got %h %h %h want F0003E F001FF F00201", wr_q[0], wr_q[1], wr_q[2]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL good_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        drive(8'hA5); drive(8'hF0); drive(8'h00); drive(8'h00); drive(8'h03);
        drive(8'h3E); drive(8'hFF); drive(8'h01); drive(8'hCE);
        n_checks++; if ({load_done, cpu_hold, load_error, busy} !== 4'b0110) begin n_fail++; $display("FAIL bad_chk got %b want 0110", {load_done, cpu_hold, load_error, busy}); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_q.size() !== 3 || done_cnt !== 0) begin n_fail++; $display("FAIL bad_chk_log got wr=%0d done=%0d want 3 0", wr_q.size(), done_cnt); end
        n_checks++; if ({cpu_hold, load_error} !== 2'b11) begin n_fail++; $display("FAIL bad_chk_sticky got %b want 11", {cpu_hold, load_error}); end
        // Recovery frame: sync clears the error, good checksum releases the CPU.
        clear_log();
        drive(8'hA5);
        n_checks++; if ({cpu_hold, load_error} !== 2'b10) begin n_fail++; $display("FAIL recover_sync got %b want 10", {cpu_hold, load_error}); end
        drive(8'hF0); drive(8'h00); drive(8'h00); drive(8'h03);
        drive(8'h3E); drive(8'hFF); drive(8'h01); drive(8'hCF);
        n_checks++; if ({load_done, cpu_hold, load_error} !== 3'b100) begin n_fail++; $display("FAIL recover_done got %b want 100", {load_done, cpu_hold, load_error}); end
    endtask

    task automatic test_wrap();
        clear_log();
        drive(8'hA5); drive(8'hFF); drive(8'hFF); drive(8'h00); drive(8'h02);
        drive(8'h11);
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 25'h1_FFFF_11) begin n_fail++; $display("FAIL wrap_first got %h want 1FFFF11", {mem_we, mem_addr, mem_wdata}); end
        drive(8'h22);
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 25'h1_0000_22) begin n_fail++; $display("FAIL wrap_second got %h want 1000022", {mem_we, mem_addr, mem_wdata}); end
        drive(8'hCD);
        n_checks++; if ({load_done, cpu_hold, mem_we} !== 3'b100) begin n_fail++; $display("FAIL wrap_done got %b want 100", {load_done, cpu_hold, mem_we}); end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL wrap_wr_count got %0d want 2", wr_q.size()); end
    endtask

    task automatic test_zero_len();
        clear_log();
        drive(8'hA5); drive(8'h12); drive(8'h34); drive(8'h00); drive(8'h00);
        n_checks++; if ({busy, mem_we} !== 2'b10) begin n_fail++; $display("FAIL zero_len_check got %b want 10", {busy, mem_we}); end
        drive(8'hBA);
        n_checks++; if ({load_done, cpu_hold, load_error} !== 3'b100) begin n_fail++; $display("FAIL zero_len_done got %b want 100", {load_done, cpu_hold, load_error}); end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_q.size() !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL zero_len_log got wr=%0d done=%0d want 0 1", wr_q.size(), done_cnt); end
    endtask

    task automatic test_noise();
        logic [7:0] noise [3];
        noise = '{8'h00, 8'hFF, 8'h5A};
        clear_log();
        for (int i = 0; i < 3; i++) begin
            drive(noise[i]);
            n_checks++; if ({busy, cpu_hold, mem_we, load_error} !== 4'b0000) begin n_fail++; $display("FAIL noise_%0d got %b want 0000", i, {busy, cpu_hold, mem_we, load_error}); end
        end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL noise_idle got wr=%0d busy=%b want 0 0", wr_q.size(), busy); end
    endtask

    task automatic test_timeout();
        clear_log();
        drive(8'hA5); drive(8'hF0);
        repeat (15) @(negedge clk);
        n_checks++; if ({load_error, busy, cpu_hold} !== 3'b011) begin n_fail++; $display("FAIL timeout_early got %b want 011", {load_error, busy, cpu_hold}); end
        @(negedge clk);
        n_checks++; if ({load_error, busy, cpu_hold} !== 3'b101) begin n_fail++; $display("FAIL timeout_expire got %b want 101", {load_error, busy, cpu_hold}); end
    endtask

    task automatic test_reset_mid_data();
        clear_log();
        drive(8'hA5); drive(8'h00); drive(8'h10); drive(8'h00); drive(8'h08);
        drive(8'h01); drive(8'h02);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({cpu_hold, busy, mem_we, load_error} !== 4'b0000) begin n_fail++; $display("FAIL reset_async got %b want 0000", {cpu_hold, busy, mem_we, load_error}); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i < 9; i++) drive(8'(i * 16 + i));
        repeat (2) @(negedge clk);
        n_checks++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL reset_wr_count got %0d want 2", wr_q.size()); end
        n_checks++; if ({busy, cpu_hold, load_done} !== 3'b000) begin n_fail++; $display("FAIL reset_after got %b want 000", {busy, cpu_hold, load_done}); end
    endtask

    initial begin
        done_cnt = 0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_wrap();
        test_zero_len();
        test_noise();
        test_timeout();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
